// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage data port: one request at a time,
// configurable wait states, byte/half/word access on an internal word array.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  lat_write;
    logic [31:0]           lat_addr;
    logic [31:0]           lat_wdata;
    logic [2:0]            lat_funct3;
    logic [31:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           cur_word;
    logic [31:0]           merged_word;
    logic [31:0]           load_data;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic                  bad_funct3;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  err;

    assign word_idx     = lat_addr[ADDR_WIDTH+1:2];
    assign lane         = lat_addr[1:0];
    assign cur_word     = mem[word_idx];
    assign sel_byte     = cur_word[{lane, 3'b000} +: 8];
    assign sel_half     = lat_addr[1] ? cur_word[31:16] : cur_word[15:0];
    assign out_of_range = (lat_addr >> (ADDR_WIDTH + 2)) != 32'd0;

    // Rejection is decided only from the latched request, never from live inputs
    always_comb begin
        if (lat_write) begin
            bad_funct3 = lat_funct3 > 3'b010;
        end else begin
            bad_funct3 = (lat_funct3 == 3'b011) || (lat_funct3[2:1] == 2'b11);
        end
        misaligned = ((lat_funct3[1:0] == 2'b01) && lane[0]) ||
                     ((lat_funct3[1:0] == 2'b10) && (lane != 2'b00));
        err = bad_funct3 || misaligned || out_of_range;
    end

    always_comb begin
        case (lat_funct3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_data = cur_word;
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        merged_word = cur_word;
        case (lat_funct3[1:0])
            2'b00:   merged_word[{lane, 3'b000} +: 8] = lat_wdata[7:0];
            2'b01:   merged_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            2'b10:   merged_word = lat_wdata;
            default: merged_word = cur_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            lat_write  <= req_write;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
        end
    end

    // A reset landing on the ACCESS edge must discard the pending store
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_ACCESS && lat_write && !err) begin
            mem[word_idx] <= merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (WAIT_CYCLES > 0) begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    rsp_err   <= err;
                    rsp_rdata <= (err || lat_write) ? 32'd0 : load_data;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed and random requests are checked
// against a byte-level memory model; a second instance covers zero wait states.
module tb_dmem_responder;

    localparam int AW    = 10;
    localparam int WC    = 2;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        rst_n_z;
    logic        req_valid_z, req_ready_z, req_write_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic [2:0]  req_funct3_z;
    logic        rsp_valid_z, rsp_ready_z, rsp_err_z, busy_z;
    logic [31:0] rsp_rdata_z;

    int          checks = 0;
    int          failures = 0;
    int          ready_mode = 0;
    exp_t        sb_q[$];
    logic [31:0] model_mem [int];

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n_z),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_funct3(req_funct3_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
        .rsp_err(rsp_err_z), .busy(busy_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelWord(input int idx);
        if (model_mem.exists(idx)) return model_mem[idx];
        return 32'd0;
    endfunction

    // Reference: memory as bytes; access size is 1, 2 or 4 bytes from funct3
    function automatic exp_t modelAccess(input bit wr, input logic [31:0] addr,
                                         input logic [31:0] wd, input logic [2:0] f3);
        exp_t        e;
        int          size;
        int          off;
        bit          bad;
        logic [31:0] word;
        logic [31:0] val;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        bad  = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        size = 1 << f3[1:0];
        if (bad || (addr % size) != 0 || addr >= 32'(4 * DEPTH)) begin
            e.err = 1'b1;
            return e;
        end
        off  = int'(addr % 4);
        word = modelWord(int'(addr / 4));
        if (wr) begin
            for (int i = 0; i < size; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
            model_mem[int'(addr / 4)] = word;
        end else begin
            val = word >> (8 * off);
            if (size == 1) val = val & 32'h0000_00FF;
            if (size == 2) val = val & 32'h0000_FFFF;
            if (!f3[2] && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
            if (!f3[2] && size == 2 && val[15]) val = val | 32'hFFFF_0000;
            e.rdata = val;
        end
        return e;
    endfunction

    // Responder-side requester: rsp_ready updated just after each rising edge
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 9) < 7);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: each response is popped once and re-checked every stalled cycle
    initial begin
        bit   have_cur;
        exp_t cur;
        have_cur = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (!have_cur) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        cur = sb_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    checkOutput("rsp_rdata", rsp_rdata, cur.rdata);
                    checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
                end
            end else begin
                have_cur = 1'b0;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where rsp_valid should rise
    task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [2:0] f3);
        int n;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = f3;
        req_valid  = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checkOutput("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb_q.push_back(modelAccess(wr, addr, wd, f3));
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k <= WC; k++) begin
            checkOutput("latency_early", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        checkOutput("latency_valid", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic issueThenReset(input logic [31:0] addr, input logic [31:0] wd, input int delay);
        int n;
        req_write  = 1'b1;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = 3'b010;
        req_valid  = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("rst_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (delay) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Zero-wait instance: returns at the falling edge right after acceptance
    task automatic zRequest(input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] f3);
        int n;
        req_write_z  = wr;
        req_addr_z   = addr;
        req_wdata_z  = wd;
        req_funct3_z = f3;
        req_valid_z  = 1'b1;
        n = 0;
        while (req_ready_z !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("z_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid_z = 1'b0;
        checkOutput("z_latency_early", {31'd0, rsp_valid_z}, 32'd0);
    endtask

    task automatic zExpect(input string name, input logic [31:0] rdata, input bit e);
        @(negedge clk);
        checkOutput({name, "_valid"}, {31'd0, rsp_valid_z}, 32'd1);
        checkOutput({name, "_rdata"}, rsp_rdata_z, rdata);
        checkOutput({name, "_err"}, {31'd0, rsp_err_z}, {31'd0, e});
    endtask

    initial begin
        int          n;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [2:0]  good_f3 [5];
        good_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst_n = 1'b0;  req_valid = 1'b0;  req_write = 1'b0;
        req_addr = '0; req_wdata = '0;    req_funct3 = '0;
        rst_n_z = 1'b0; req_valid_z = 1'b0; req_write_z = 1'b0;
        req_addr_z = '0; req_wdata_z = '0; req_funct3_z = '0;
        rsp_ready_z = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        rst_n_z = 1'b1;
        $display("[TB] directed word, sub-word and error cases");

        applyStimulus(1, 32'h10, 32'hDEADBEEF, 3'b010);
        applyStimulus(0, 32'h10, 32'h0, 3'b010);
        applyStimulus(1, 32'h20, 32'h11223344, 3'b010);
        applyStimulus(1, 32'h21, 32'hFFFFFF80, 3'b000);
        applyStimulus(0, 32'h20, 32'h0, 3'b010);
        applyStimulus(0, 32'h21, 32'h0, 3'b000);
        applyStimulus(0, 32'h21, 32'h0, 3'b100);
        applyStimulus(1, 32'h22, 32'h0000ABCD, 3'b001);
        applyStimulus(0, 32'h22, 32'h0, 3'b001);
        applyStimulus(0, 32'h22, 32'h0, 3'b101);
        applyStimulus(1, 32'h30, 32'h5A5A5A5A, 3'b010);
        applyStimulus(0, 32'h13, 32'h0, 3'b010);
        applyStimulus(0, 32'h11, 32'h0, 3'b001);
        applyStimulus(1, 32'h1000, 32'hFFFFFFFF, 3'b010);
        applyStimulus(0, 32'h30, 32'h0, 3'b011);
        applyStimulus(1, 32'h31, 32'hFFFFFFFF, 3'b010);
        applyStimulus(1, 32'h30, 32'hFFFFFFFF, 3'b011);
        applyStimulus(0, 32'h30, 32'h0, 3'b010);

        $display("[TB] backpressure");
        applyStimulus(1, 32'h50, 32'h0BADF00D, 3'b010);
        ready_mode = 0;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ready_mode = 2;
        applyStimulus(0, 32'h50, 32'h0, 3'b010);
        req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
            checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            @(negedge clk);
        end
        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_release_idle", {31'd0, req_ready}, 32'd1);
        applyStimulus(0, 32'h10, 32'h0, 3'b010);

        $display("[TB] reset during operation");
        issueThenReset(32'h40, 32'h12345678, 0);
        applyStimulus(0, 32'h40, 32'h0, 3'b010);
        issueThenReset(32'h40, 32'h12345678, 2);
        applyStimulus(0, 32'h40, 32'h0, 3'b010);

        $display("[TB] randomized traffic");
        ready_mode = 1;
        for (int t = 0; t < 150; t++) begin
            wr   = $urandom_range(0, 1);
            addr = 32'h80 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) addr = addr | (32'd1 << $urandom_range(12, 31));
            f3 = good_f3[$urandom_range(0, 4)];
            if (wr) f3 = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            applyStimulus(wr, addr, $urandom, f3);
        end

        $display("[TB] zero wait states");
        zRequest(1, 32'h40, 32'h12345678, 3'b010);
        rst_n_z = 1'b0;
        @(negedge clk);
        checkOutput("z_rst_busy", {31'd0, busy_z}, 32'd0);
        checkOutput("z_rst_rsp_valid", {31'd0, rsp_valid_z}, 32'd0);
        rst_n_z = 1'b1;
        zRequest(0, 32'h40, 32'h0, 3'b010);
        zExpect("z_lw40", 32'h00000000, 1'b0);
        zRequest(1, 32'h44, 32'hCAFEF00D, 3'b010);
        zExpect("z_sw44", 32'h00000000, 1'b0);
        zRequest(0, 32'h44, 32'h0, 3'b010);
        zExpect("z_lw44", 32'hCAFEF00D, 1'b0);
        zRequest(0, 32'h46, 32'h0, 3'b001);
        zExpect("z_lh46", 32'hFFFFCAFE, 1'b0);

        ready_mode = 0;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
